// File: rtl/mul_seq_unit_pkg.sv
// -----------------------------------------------------------------------------
// mul_seq_unit_pkg
//   Shared definitions for the sequential shift-and-add multiplier:
//   FSM state encoding, default operand width and the counter-width helper.
// -----------------------------------------------------------------------------
package mul_seq_unit_pkg;

  // Default operand width; the product is twice this wide.
  localparam int MUL_WIDTH = 24;

  // FSM states. Encoding is fixed so other blocks can decode it if needed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Iteration counter width: enough to count 0 .. width-1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage : mul_seq_unit_pkg

// File: rtl/mul_seq_unit_if.sv
// -----------------------------------------------------------------------------
// mul_seq_unit_if
//   Request/response bundle between the core control and the multiplier.
//   Signals:
//     start       request, honoured only when the multiplier is idle or done
//     is_signed   1 = two's-complement operands, 0 = unsigned
//     a, b        multiplicand / multiplier
//     busy        multiplication in progress (core stalls the PC)
//     done        one-cycle pulse, product_hi/product_lo valid
//     product_hi  upper half of the 2*WIDTH product
//     product_lo  lower half of the 2*WIDTH product
//   master = requester (core), slave = multiplier.
// -----------------------------------------------------------------------------
import mul_seq_unit_pkg::*;

interface mul_seq_unit_if #(
  parameter int WIDTH = MUL_WIDTH
) ();

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, product_hi, product_lo
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, product_hi, product_lo
  );

endinterface : mul_seq_unit_if

// File: rtl/mul_seq_unit_sign_fix.sv
// -----------------------------------------------------------------------------
// mul_sign_fix
//   Combinational conditional two's-complement negate.
//   Ports:
//     i_data  value to correct
//     i_neg   1 = output -i_data (mod 2^W), 0 = pass through
//     o_data  corrected value
//   Used for operand magnitudes and for the final product sign correction.
//   Negating the most negative value wraps to itself, which is exactly the
//   unsigned magnitude wanted for |0x80..0|.
// -----------------------------------------------------------------------------
module mul_sign_fix #(
  parameter int W = 24
) (
  input  logic [W-1:0] i_data,
  input  logic         i_neg,
  output logic [W-1:0] o_data
);

  logic [W-1:0] w_negated;

  assign w_negated = ~i_data + W'(1);
  assign o_data    = i_neg ? w_negated : i_data;

endmodule : mul_sign_fix

// File: rtl/mul_seq_unit.sv
// -----------------------------------------------------------------------------
// mul_seq_unit
//   Multi-cycle shift-and-add multiplier (one multiplier bit per clock) that
//   sits beside the single-cycle ALU for MUL/MULH. Signed operation uses
//   sign-magnitude: magnitudes are multiplied unsigned and the product is
//   negated at the end when the operand signs differ.
//   Ports:
//     i_clk    system clock, all state on the rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      mul_seq_unit_if.slave (start/is_signed/a/b in,
//              busy/done/product_hi/product_lo out)
//   Timing: capture edge, WIDTH RUN edges, one FIX edge, then Done for one
//   cycle. Busy covers RUN and FIX.
// -----------------------------------------------------------------------------
import mul_seq_unit_pkg::*;

module mul_seq_unit #(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  mul_seq_unit_if.slave    bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PW    = 2 * WIDTH;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic               r_neg;
  logic [PW-1:0]      r_acc;
  logic [WIDTH-1:0]   r_prod_hi;
  logic [WIDTH-1:0]   r_prod_lo;

  logic               w_capture;
  logic               w_last_iter;
  logic               w_neg_a;
  logic               w_neg_b;
  logic               w_sign_xor;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [PW-1:0]      w_acc_nxt;
  logic [PW-1:0]      w_prod_fix;
  logic               w_busy;
  logic               w_done;

  // Operand magnitudes: only negate when the operation is signed.
  assign w_neg_a    = bus.is_signed & bus.a[WIDTH-1];
  assign w_neg_b    = bus.is_signed & bus.b[WIDTH-1];
  assign w_sign_xor = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];

  mul_sign_fix #(.W(WIDTH)) u_fix_a (
    .i_data (bus.a),
    .i_neg  (w_neg_a),
    .o_data (w_mag_a)
  );

  mul_sign_fix #(.W(WIDTH)) u_fix_b (
    .i_data (bus.b),
    .i_neg  (w_neg_b),
    .o_data (w_mag_b)
  );

  // Final sign correction of the unsigned magnitude product.
  mul_sign_fix #(.W(PW)) u_fix_prod (
    .i_data (r_acc),
    .i_neg  (r_neg),
    .o_data (w_prod_fix)
  );

  assign w_capture   = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));

  // One shift-add iteration. The adder is WIDTH+1 bits so the carry out of
  // the upper half drops into the MSB when the accumulator shifts right.
  assign w_addend  = r_mag_b[0] ? r_mag_a : '0;
  assign w_sum     = {1'b0, r_acc[PW-1:WIDTH]} + {1'b0, w_addend};
  assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last_iter) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = bus.start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the registered state only
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_RUN,
      ST_FIX:  w_busy = 1'b1;
      ST_DONE: w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.product_hi = r_prod_hi;
  assign bus.product_lo = r_prod_lo;

  // Datapath: capture, iterate, then register the corrected product.
  // Everything clears on reset so no partial result survives an abort.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_mag_a   <= '0;
      r_mag_b   <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_prod_hi <= '0;
      r_prod_lo <= '0;
    end else if (w_capture) begin
      r_mag_a <= w_mag_a;
      r_mag_b <= w_mag_b;
      r_neg   <= bus.is_signed & w_sign_xor;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc   <= w_acc_nxt;
      r_mag_b <= r_mag_b >> 1;
      r_cnt   <= r_cnt + CNT_W'(1);
    end else if (r_state == ST_FIX) begin
      // A zero magnitude negates to zero, so no negative zero can appear.
      r_prod_hi <= w_prod_fix[PW-1:WIDTH];
      r_prod_lo <= w_prod_fix[WIDTH-1:0];
    end
  end

endmodule : mul_seq_unit

// File: tb/tb_mul_seq_unit.sv
module tb_mul_seq_unit;
  localparam int W = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_seq_unit_if #(.WIDTH(W)) bus ();

  mul_seq_unit #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: edge counter, pending op, visible product.
  int             k      = 0;
  bit             m_act  = 1'b0;
  int             m_c0   = 0;
  logic [2*W-1:0] m_pend = '0;
  logic [2*W-1:0] m_prod = '0;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic s);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    logic signed [2*W-1:0] sp;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      sp = sa * sb;
      return sp;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request at edge c0 produces its product on edge
  // c0+W+1; requests are accepted only when no op is still running.
  always @(posedge clk) begin
    k++;
    if (rst_n) begin
      if (m_act && (k == m_c0 + W + 1)) m_prod = m_pend;
      if (bus.start && (!m_act || (k > m_c0 + W + 1))) begin
        m_act  = 1'b1;
        m_c0   = k;
        m_pend = ref_mul(bus.a, bus.b, bus.is_signed);
      end
    end
  end

  always @(negedge rst_n) begin
    m_act  = 1'b0;
    m_prod = '0;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic exp_busy;
    logic exp_done;
    exp_busy = m_act && (k >= m_c0) && (k <= m_c0 + W);
    exp_done = m_act && (k == m_c0 + W + 1);
    check("cyc_busy", 64'(bus.busy), 64'(exp_busy));
    check("cyc_done", 64'(bus.done), 64'(exp_done));
    check("cyc_hi",   64'(bus.product_hi), 64'(m_prod[2*W-1:W]));
    check("cyc_lo",   64'(bus.product_lo), 64'(m_prod[W-1:0]));
  end

  // Drive a request at a negedge; returns at the negedge after capture.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  // Wait (bounded) for Done; counts Busy cycles seen before it.
  task automatic wait_done(output bit ok, output int busy_cyc);
    ok       = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) busy_cyc++;
      @(negedge clk);
    end
    if (!ok) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    bit ok;
    int bc;
    int k0;
    start_op(a, b, s);
    k0 = k;
    wait_done(ok, bc);
    if (ok) begin
      check({name, "_latency"}, 64'(k - k0), 64'd25);
      check({name, "_busycyc"}, 64'(bc), 64'd25);
      check({name, "_hi"}, 64'(bus.product_hi), 64'(exp_hi));
      check({name, "_lo"}, 64'(bus.product_lo), 64'(exp_lo));
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    bit ok;
    int bc;
    int kd;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi",   64'(bus.product_hi), 64'd0);
    check("rst_lo",   64'(bus.product_lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("u3x5",    24'h000003, 24'h000005, 1'b0, 24'h000000, 24'h00000F);
    run_op("sm1x1",   24'hFFFFFF, 24'h000001, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
    run_op("smin2",   24'h800000, 24'h800000, 1'b1, 24'h400000, 24'h000000);
    run_op("sminx1",  24'h800000, 24'h000001, 1'b1, 24'hFFFFFF, 24'h800000);
    run_op("umax2",   24'hFFFFFF, 24'hFFFFFF, 1'b0, 24'hFFFFFE, 24'h000001);
    run_op("zeroneg", 24'h000000, 24'h800000, 1'b1, 24'h000000, 24'h000000);
    run_op("sm1sq",   24'hFFFFFF, 24'hFFFFFF, 1'b1, 24'h000000, 24'h000001);

    // Start pulses during RUN are ignored; Start on Done chains a new op.
    start_op(24'h000003, 24'h000005, 1'b0);
    repeat (4) @(negedge clk);
    bus.a = 24'h000009; bus.b = 24'h000009; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(ok, bc);
    if (ok) begin
      check("ign_lo", 64'(bus.product_lo), 64'h00000F);
      check("ign_hi", 64'(bus.product_hi), 64'h000000);
      kd = k;
      bus.a = 24'h000007; bus.b = 24'h000006; bus.is_signed = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(ok, bc);
      if (ok) begin
        check("b2b_gap", 64'(k - kd), 64'd26);
        check("b2b_lo",  64'(bus.product_lo), 64'h00002A);
      end
    end
    @(negedge clk);

    // Asynchronous abort mid-RUN.
    start_op(24'hFFFFFF, 24'hFFFFFF, 1'b0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_hi",   64'(bus.product_hi), 64'd0);
    check("abort_lo",   64'(bus.product_lo), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post2x2", 24'h000002, 24'h000002, 1'b0, 24'h000000, 24'h000004);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mul_seq_unit
